// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width common to transmitter and receiver,
// and the transmitter's frame-sequencing states.
// No logic; constants and types only.
package spi_pkg;

    // Frame width of the 12-bit SPI link; the slave receiver uses the same value.
    localparam int SPI_DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_tx_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Purpose: free-running serial clock divider with one-cycle rise/fall strobes.
// Latency: strobes are asserted in the clk cycle before sync_clock changes.
// Backpressure: none; runs continuously out of reset.
// Ports: clk, rst_n (sync, active low) in; sync_clock, rise_tick, fall_tick out.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_clock,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Strobes lead the edge by one cycle so that registers updated on a
    // strobe change in the same clk cycle as sync_clock itself.
    assign rise_tick  = w_wrap & ~r_sclk;
    assign fall_tick  = w_wrap &  r_sclk;
    assign sync_clock = r_sclk;

endmodule

// File: rtl/spi_master_tx.sv
// Purpose: 12-bit SPI transmit master, LSB first, CS/MOSI changed only on sync_clock falling edges.
// Latency: accept -> CS low 1..2*CLK_DIV clk; CS low -> done (DATA_W+2)*2*CLK_DIV clk; done -> next CS low >= 2*CLK_DIV.
// Backpressure: ready low while a frame or GAP is in progress; newd without ready is dropped.
// Ports: clk, rst_n (sync, active low), newd, din[DATA_W] in;
//        ready, busy, sync_clock, CS (active low), MOSI, done (1-clk pulse) out.
// Build option: define SPI_TX_BUF_EN for a one-entry holding register (back-to-back frames).
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              busy,
    output logic              sync_clock,
    output logic              CS,
    output logic              MOSI,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_tx_state_e     r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_cs, w_cs_nxt;
    logic              r_mosi, w_mosi_nxt;
    logic              r_done, w_done_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_saw_rise;

    logic              w_fall_tick;
    logic              w_rise_tick;
    logic              w_idle_free;
    logic              w_gap_exit;
    logic              w_load_direct;
    logic              w_ready;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clock (sync_clock),
        .rise_tick  (w_rise_tick),
        .fall_tick  (w_fall_tick)
    );

    assign w_idle_free = (r_state == IDLE) && !r_busy;
    // GAP is only left once a rising edge has been seen with CS high, so
    // the slave is guaranteed to observe the deselect and re-arm.
    assign w_gap_exit  = (r_state == GAP) && w_fall_tick && r_saw_rise;

`ifdef SPI_TX_BUF_EN
    logic [DATA_W-1:0] r_buf;
    logic              r_buf_vld;
    logic              w_drain;
    logic              w_buf_wr;

    // The holding register empties either straight into the next frame at
    // GAP exit, or into shreg when it was filled on the very GAP-exit edge.
    assign w_drain       = r_buf_vld && (w_gap_exit || w_idle_free);
    assign w_ready       = !r_buf_vld || w_drain;
    assign w_load_direct = newd && w_idle_free && !r_buf_vld;
    assign w_buf_wr      = newd && w_ready && !w_load_direct;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
        end else if (w_buf_wr) begin
            r_buf     <= din;
            r_buf_vld <= 1'b1;
        end else if (w_drain) begin
            r_buf_vld <= 1'b0;
        end
    end
`else
    assign w_ready       = w_idle_free;
    assign w_load_direct = newd && w_idle_free;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cs_nxt      = r_cs;
        w_mosi_nxt    = r_mosi;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = r_busy;

        case (r_state)
            IDLE: begin
                if (w_load_direct) begin
                    w_shreg_nxt = din;
                    w_busy_nxt  = 1'b1;
                end
`ifdef SPI_TX_BUF_EN
                else if (w_drain) begin
                    w_shreg_nxt = r_buf;
                    w_busy_nxt  = 1'b1;
                end
`endif
                if (r_busy && w_fall_tick) begin
                    w_cs_nxt    = 1'b0;
                    w_state_nxt = SETUP;
                end
            end
            // The rising edge inside SETUP is the slave's CS-detect edge.
            SETUP: begin
                if (w_fall_tick) begin
                    w_mosi_nxt    = r_shreg[0];
                    w_shreg_nxt   = r_shreg >> 1;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_fall_tick) begin
                    if (r_bit_cnt == CNT_W'(DATA_W)) begin
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = HOLD;
                    end else begin
                        w_mosi_nxt    = r_shreg[0];
                        w_shreg_nxt   = r_shreg >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            // The rising edge inside HOLD is the slave's done edge.
            HOLD: begin
                if (w_fall_tick) begin
                    w_cs_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (w_gap_exit) begin
`ifdef SPI_TX_BUF_EN
                    if (r_buf_vld) begin
                        // Chain straight into the next frame: one GAP only.
                        w_shreg_nxt   = r_buf;
                        w_bit_cnt_nxt = '0;
                        w_busy_nxt    = 1'b1;
                        w_cs_nxt      = 1'b0;
                        w_state_nxt   = SETUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_saw_rise <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_cs       <= w_cs_nxt;
            r_mosi     <= w_mosi_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            if (w_fall_tick) begin
                r_saw_rise <= 1'b0;
            end else if (w_rise_tick) begin
                r_saw_rise <= 1'b1;
            end
        end
    end

    assign ready = w_ready;
    assign busy  = r_busy;
    assign CS    = r_cs;
    assign MOSI  = r_mosi;
    assign done  = r_done;

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Transmit end of the 12-bit SPI link. It accepts a parallel word from the system side and serializes it LSB-first on MOSI. It generates the free-running `sync_clock` and the active-low `CS` framing that the existing SPI slave receiver expects, so a slave attached to these three wires captures exactly one word per frame and raises its own `done`.

## Interface

Parameters:
- `DATA_W`, 12, frame width; must equal the receiver's width.
- `CLK_DIV`, 4, number of `clk` cycles per `sync_clock` half-period; minimum 2.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on `posedge clk`.
- `newd` input 1: start request, sampled on `posedge clk`.
- `din` input DATA_W: word to send; captured when `newd` is accepted.
- `ready` output 1: a `newd` in this cycle will be accepted.
- `busy` output 1: a frame is in progress.
- `sync_clock` output 1: serial clock; free-running, period 2·CLK_DIV `clk` cycles.
- `CS` output 1: chip select, active low.
- `MOSI` output 1: serial data.
- `done` output 1: one-`clk` pulse at frame end.

## Operation

- Divider counts 0..CLK_DIV-1 and toggles `sync_clock` on wrap.
  - Fall tick: the `clk` cycle in which `sync_clock` goes 1→0.
  - Rise tick: the `clk` cycle in which `sync_clock` goes 0→1.
- All `CS` and `MOSI` changes happen only on fall ticks, so the slave always samples on rising edges with half a period of setup.
- Word register `shreg` is DATA_W bits; `bit_cnt` is 0..DATA_W.
- States and transitions:
  - IDLE: `CS`=1, `MOSI`=0. Accept `newd`: load `shreg`=`din`, `busy`=1. On the next fall tick, `CS`←0 and go to SETUP.
  - SETUP: on the next fall tick, `MOSI`←`shreg[0]`, shift right, `bit_cnt`=1, go to SHIFT. The rising edge inside SETUP is the slave's CS-detect edge; it carries no data.
  - SHIFT: each fall tick, `MOSI`←next bit. After bit DATA_W-1 is driven, the next fall tick sets `MOSI`←0 and goes to HOLD.
  - HOLD: the rising edge in HOLD is the slave's done edge. On the next fall tick, `CS`←1, `done`=1 for that `clk`, `busy`←0, go to GAP.
  - GAP: `CS` stays high through at least one full rising edge, so the slave re-arms in its start state. Go to IDLE on the next fall tick.
- Frame length: `CS` low for exactly DATA_W+2 `sync_clock` periods, i.e. 14 rising edges for DATA_W=12.
- `newd` while not `ready`: ignored, no side effects.
- `ready` = IDLE and not busy (buffer variant: see Configuration).
- `din` is only sampled on acceptance; later changes do not affect the frame.

## Timing

- Reset (`rst_n`=0 at `posedge clk`), at any point including mid-frame, forces:
  - `sync_clock`=0, divider=0
  - `CS`=1, `MOSI`=0, `done`=0, `busy`=0, `ready`=1 in the cycle after release
  - state=IDLE; `shreg`, `bit_cnt`, and buffer cleared
- An aborted frame is simply truncated. The slave is resynchronized by `CS`=1.
- Acceptance → `CS` low: 1 to 2·CLK_DIV `clk` cycles (wait for the next fall tick).
- `CS` low → `done`: (DATA_W+2)·2·CLK_DIV `clk` cycles exactly.
- `done` → earliest next `CS` low: 2·CLK_DIV `clk` cycles (GAP).
- `newd` in the same cycle as `done`: not accepted in the base variant (`ready`=0 until GAP ends).

## Configuration

- `SPI_TX_BUF_EN` defined:
  - Adds a one-entry holding register. `ready` = holding register empty, and `newd` is accepted during any state.
  - On leaving GAP with the holding register full, its word is loaded into `shreg` and the frame begins without returning `ready` through IDLE. Back-to-back frames are separated by exactly one GAP.
  - A `newd` in the same cycle the holding register drains is accepted.
- Undefined: no holding register, and behaviour is as in Operation.

## Structure

- Package `spi_pkg`:
  - `DATA_W` default constant, shared with the receiver.
  - Enum `spi_tx_state_e` {IDLE, SETUP, SHIFT, HOLD, GAP}.
- Sub-module `spi_clk_gen` (parameter CLK_DIV): produces `sync_clock` plus single-cycle `rise_tick`/`fall_tick` strobes, and is reset by `rst_n`.
- The FSM and shifter live in `spi_master_tx`.

## Test plan

- Single word: `din`=12'hA5C, `newd` pulse. Expect:
  - MOSI at rising edges 2..13 = 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first)
  - `CS` low for 14 rising edges, one `done` pulse
  - attached slave `dout`=12'hA5C with slave `done`.
- Latency with CLK_DIV=4: `CS` low → `done` = 112 `clk` cycles, and `CS` high for ≥8 cycles before the next frame.
- `newd` with `din`=12'h123 while busy sending 12'hFFF (base variant): ignored. Slave receives only 12'hFFF; `ready`=0 throughout.
- With `SPI_TX_BUF_EN`: send 12'h001 then 12'h800 back-to-back. Slave sees 12'h001 then 12'h800 with exactly one GAP between frames, and `done` pulses twice.
- `rst_n` low at rising edge 7 of a frame: next cycle `CS`=1, `MOSI`=0, `busy`=0. A following frame with 12'h5A5 is received intact.
